// File: rtl/uart_rx_pkg.sv
// Shared types and frame-geometry constants for the UART receive timing generator.
// frame_len() gives the total bit count of one frame from the character options.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam int MIN_PRESCALE_DEF = 4;
  localparam int START_BITS       = 1;
  localparam int DATA_BASE        = 5;

  function automatic logic [4:0] frame_len(input logic [1:0] data_bits,
                                           input logic       par_en,
                                           input logic       stop2);
    logic [4:0] stop_bits_s;
    if (stop2) begin
      stop_bits_s = 5'd2;
    end else begin
      stop_bits_s = 5'd1;
    end
    return 5'(START_BITS) + 5'(DATA_BASE) + {3'b000, data_bits} + {4'b0000, par_en} + stop_bits_s;
  endfunction

endpackage

// File: rtl/uart_rx_edge_cnt.sv
// Wrapping edge counter: counts 0..max_val while en is high, returns to 0 when en is low.
// tc flags the terminal count and depends on registered state only.
module uart_rx_edge_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == max_val);

  // Edge position within the current bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_timing_gen.sv
// Receive-side bit timing for a UART: tracks edge/bit position within a frame and
// decodes the mid-bit sample strobes, bit and frame boundaries from registered state.
module uart_rx_timing_gen
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W   = 6,
  parameter int BITCNT_W     = 4,
  parameter int MIN_PRESCALE = MIN_PRESCALE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [1:0]            data_bits,
  input  logic                  par_en,
  input  logic                  stop2,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BITCNT_W-1:0]   bit_cnt,
  output logic                  sample_stb,
  output logic [1:0]            sample_idx,
  output logic                  bit_end,
  output logic                  frame_end,
  output logic                  cfg_err
);

  state_t                state_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic [1:0]            data_bits_r;
  logic                  par_en_r;
  logic                  stop2_r;
  logic                  cfg_err_r;
  logic [BITCNT_W-1:0]   bit_cnt_r;

  logic                  run_s;
  logic                  adv_s;
  logic                  tc_s;
  logic                  last_bit_s;
  logic [PRESCALE_W-1:0] edge_max_s;
  logic [PRESCALE_W-1:0] mid_s;
  logic [BITCNT_W-1:0]   fl_m1_s;

  logic                  sample_stb_s;
  logic [1:0]            sample_idx_s;
  logic                  bit_end_s;
  logic                  frame_end_s;

  assign run_s      = (state_r == ST_RUN);
  assign adv_s      = run_s & enable;
  assign edge_max_s = prescale_r - PRESCALE_W'(1);
  assign mid_s      = prescale_r >> 1;
  assign fl_m1_s    = BITCNT_W'(frame_len(data_bits_r, par_en_r, stop2_r)) - BITCNT_W'(1);
  assign last_bit_s = (bit_cnt_r == fl_m1_s);

  uart_rx_edge_cnt #(
    .W (PRESCALE_W)
  ) u_edge_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (adv_s),
    .max_val (edge_max_s),
    .cnt     (edge_cnt),
    .tc      (tc_s)
  );

  // Frame state, configuration latch and sticky configuration error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      prescale_r  <= '0;
      data_bits_r <= 2'd0;
      par_en_r    <= 1'b0;
      stop2_r     <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            prescale_r  <= prescale;
            data_bits_r <= data_bits;
            par_en_r    <= par_en;
            stop2_r     <= stop2;
            if (prescale >= PRESCALE_W'(MIN_PRESCALE)) begin
              state_r   <= ST_RUN;
              cfg_err_r <= 1'b0;
            end else begin
              state_r   <= ST_ERR;
              cfg_err_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state_r <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (!enable) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Bit index: advances on each bit's last edge, wraps after the final stop bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r <= '0;
    end else if (!adv_s) begin
      bit_cnt_r <= '0;
    end else if (tc_s) begin
      if (last_bit_s) begin
        bit_cnt_r <= '0;
      end else begin
        bit_cnt_r <= bit_cnt_r + BITCNT_W'(1);
      end
    end
  end

  // Strobe decode; the three samples straddle the bit centre at mid-1, mid, mid+1
  always_comb begin
    sample_stb_s = 1'b0;
    sample_idx_s = 2'd0;
    bit_end_s    = 1'b0;
    frame_end_s  = 1'b0;
    if (run_s) begin
      bit_end_s   = tc_s;
      frame_end_s = tc_s & last_bit_s;
      if (edge_cnt == mid_s - PRESCALE_W'(1)) begin
        sample_stb_s = 1'b1;
        sample_idx_s = 2'd0;
      end else if (edge_cnt == mid_s) begin
        sample_stb_s = 1'b1;
        sample_idx_s = 2'd1;
      end else if (edge_cnt == mid_s + PRESCALE_W'(1)) begin
        sample_stb_s = 1'b1;
        sample_idx_s = 2'd2;
      end else begin
        sample_stb_s = 1'b0;
        sample_idx_s = 2'd0;
      end
    end else begin
      sample_stb_s = 1'b0;
      sample_idx_s = 2'd0;
      bit_end_s    = 1'b0;
      frame_end_s  = 1'b0;
    end
  end

  assign bit_cnt    = bit_cnt_r;
  assign cfg_err    = cfg_err_r;
  assign sample_stb = sample_stb_s;
  assign sample_idx = sample_idx_s;
  assign bit_end    = bit_end_s;
  assign frame_end  = frame_end_s;

endmodule

// File: tb/tb_uart_rx_timing_gen.sv
// Self-checking bench: a time-since-frame-start model predicts every output each cycle,
// plus directed checks at the frame boundaries, aborts, config errors and async reset.
module tb_uart_rx_timing_gen;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [5:0] prescale;
  logic [1:0] data_bits;
  logic       par_en;
  logic       stop2;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sample_stb;
  logic [1:0] sample_idx;
  logic       bit_end;
  logic       frame_end;
  logic       cfg_err;

  logic [15:0] obs_s;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int be_cnt  = 0;
  int fe_cnt  = 0;

  // model: 0 idle, 1 receiving, 2 config error; m_t = edges since frame start
  int m_st = 0;
  int m_t  = 0;
  int m_p  = 0;
  int m_fl = 0;
  logic m_cfgerr = 1'b0;

  uart_rx_timing_gen dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .prescale   (prescale),
    .data_bits  (data_bits),
    .par_en     (par_en),
    .stop2      (stop2),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .sample_stb (sample_stb),
    .sample_idx (sample_idx),
    .bit_end    (bit_end),
    .frame_end  (frame_end),
    .cfg_err    (cfg_err)
  );

  assign obs_s = {edge_cnt, bit_cnt, sample_stb, sample_idx, bit_end, frame_end, cfg_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_vec();
    int e, b, mid;
    logic stb, be, fe;
    logic [1:0] idx;
    if (m_st == 1) begin
      e   = m_t % m_p;
      b   = m_t / m_p;
      mid = m_p / 2;
      be  = (e == m_p - 1);
      fe  = be && (b == m_fl - 1);
      stb = (e >= mid - 1) && (e <= mid + 1);
      idx = stb ? 2'(e - mid + 1) : 2'd0;
      return {6'(e), 4'(b), stb, idx, be, fe, m_cfgerr};
    end else begin
      return {6'd0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, m_cfgerr};
    end
  endfunction

  task automatic model_reset();
    m_st = 0;
    m_t = 0;
    m_p = 0;
    m_fl = 0;
    m_cfgerr = 1'b0;
  endtask

  // advance the model using the inputs the DUT sampled at this edge
  task automatic model_step();
    case (m_st)
      0: begin
        if (enable) begin
          m_p  = int'(prescale);
          m_fl = 1 + 5 + int'(data_bits) + int'(par_en) + (stop2 ? 2 : 1);
          if (m_p >= 4) begin
            m_st = 1;
            m_t = 0;
            m_cfgerr = 1'b0;
          end else begin
            m_st = 2;
            m_cfgerr = 1'b1;
          end
        end
      end
      1: begin
        if (!enable) m_st = 0;
        else begin
          m_t++;
          if (m_t == m_p * m_fl) m_t = 0;
        end
      end
      default: begin
        if (!enable) m_st = 0;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("outs", 32'(obs_s), 32'(exp_vec()));
    if (bit_end) be_cnt++;
    if (frame_end) fe_cnt++;
  endtask

  task automatic set_cfg(input int ps, input int db, input int pe, input int s2);
    prescale  = 6'(ps);
    data_bits = 2'(db);
    par_en    = 1'(pe);
    stop2     = 1'(s2);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    enable = 1'b0;
    set_cfg(0, 0, 0, 0);
    #20;
    check("reset_outs", 32'(obs_s), 32'd0);
    rst = 1'b0;
    model_reset();
    tick();

    // 8N1 at prescale 8: one frame of 80 edges
    set_cfg(8, 3, 0, 0);
    enable = 1'b1;
    be_cnt = 0;
    fe_cnt = 0;
    repeat (80) tick();
    check("8n1_frame_end", 32'(frame_end), 32'd1);
    check("8n1_bit_cnt", 32'(bit_cnt), 32'd9);
    check("8n1_fe_count", 32'(fe_cnt), 32'd1);
    check("8n1_be_count", 32'(be_cnt), 32'd10);
    enable = 1'b0;
    tick();

    // 5E2 at prescale 16: FL=9, back-to-back second frame
    set_cfg(16, 0, 1, 1);
    enable = 1'b1;
    repeat (144) tick();
    check("5p2_frame_end", 32'(frame_end), 32'd1);
    tick();
    check("5p2_restart_bit", 32'(bit_cnt), 32'd0);
    check("5p2_restart_edge", 32'(edge_cnt), 32'd0);
    check("5p2_no_fe", 32'(frame_end), 32'd0);
    enable = 1'b0;
    tick();

    // prescale changed mid-frame is ignored
    set_cfg(8, 3, 0, 0);
    enable = 1'b1;
    repeat (25) tick();
    check("latch_bit3", 32'(bit_cnt), 32'd3);
    prescale = 6'd16;
    repeat (55) tick();
    check("latch_frame_end", 32'(frame_end), 32'd1);
    enable = 1'b0;
    tick();

    // abort at bit 4 edge 5, then immediate re-enable
    set_cfg(8, 3, 0, 0);
    enable = 1'b1;
    repeat (38) tick();
    check("abort_pre_bit", 32'(bit_cnt), 32'd4);
    check("abort_pre_edge", 32'(edge_cnt), 32'd5);
    enable = 1'b0;
    tick();
    check("abort_counters", 32'({edge_cnt, bit_cnt}), 32'd0);
    check("abort_no_fe", 32'(frame_end), 32'd0);
    enable = 1'b1;
    tick();
    check("reen_bit0", 32'({edge_cnt, bit_cnt}), 32'd0);
    tick();
    check("reen_edge1", 32'(edge_cnt), 32'd1);
    enable = 1'b0;
    tick();

    // illegal prescale -> ERR, then recovery
    set_cfg(3, 3, 0, 0);
    enable = 1'b1;
    tick();
    check("err_cfg_err", 32'(cfg_err), 32'd1);
    repeat (5) tick();
    check("err_no_stb", 32'({sample_stb, bit_end, frame_end}), 32'd0);
    enable = 1'b0;
    tick();
    check("err_sticky_idle", 32'(cfg_err), 32'd1);
    prescale = 6'd8;
    enable = 1'b1;
    tick();
    check("err_cleared", 32'(cfg_err), 32'd0);
    repeat (20) tick();

    // asynchronous reset mid-frame at prescale 32
    enable = 1'b0;
    tick();
    set_cfg(32, 3, 1, 1);
    enable = 1'b1;
    repeat (100) tick();
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_outs", 32'(obs_s), 32'd0);
    @(posedge clk);
    #1;
    enable = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_release_idle", 32'(obs_s), 32'd0);
    tick();

    // randomized frames, aborts, illegal configs and ignored mid-frame changes
    for (int k = 0; k < 40; k++) begin
      set_cfg($urandom_range(0, 20), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
      enable = 1'b1;
      n = $urandom_range(1, 400);
      for (int j = 0; j < n; j++) begin
        tick();
        if ($urandom_range(0, 15) == 0) begin
          set_cfg($urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
        end
      end
      enable = 1'b0;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_timing_gen.md
UART_RX_TIMING_GEN -- requirements
Module: uart_rx_timing_gen

Interface
REQ-001 Parameter PRESCALE_W, default 6, width of prescale input and edge counter.
REQ-002 Parameter BITCNT_W, default 4, width of bit counter; SHALL hold max frame length 12.
REQ-003 Parameter MIN_PRESCALE, default 4, smallest legal prescale value.
REQ-004 clk  in  1  single rising-edge clock; all state on this clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  high = frame reception in progress; low = abort/idle.
REQ-007 prescale  in  PRESCALE_W  clk edges per UART bit.
REQ-008 data_bits  in  2  data length minus 5 (0=5 bits .. 3=8 bits).
REQ-009 par_en  in  1  parity bit present.
REQ-010 stop2  in  1  two stop bits when high, else one.
REQ-011 edge_cnt  out  PRESCALE_W  edge position within the current bit, 0..prescale-1.
REQ-012 bit_cnt  out  BITCNT_W  bit index within frame; 0 = start bit.
REQ-013 sample_stb  out  1  pulse on each of three mid-bit sample edges.
REQ-014 sample_idx  out  2  0/1/2 = early/centre/late sample; valid with sample_stb.
REQ-015 bit_end  out  1  one-cycle pulse on the last edge of each bit.
REQ-016 frame_end  out  1  one-cycle pulse on the last edge of the last stop bit.
REQ-017 cfg_err  out  1  sticky: prescale < MIN_PRESCALE at latch time.

Function
REQ-018 FSM states SHALL be IDLE, RUN, ERR.
REQ-019 IDLE->RUN on enable high with latched prescale >= MIN_PRESCALE; IDLE->ERR if prescale < MIN_PRESCALE.
REQ-020 prescale, data_bits, par_en, stop2 SHALL be latched on the IDLE->RUN/ERR transition; later changes are ignored until IDLE.
REQ-021 Frame length FL = 1 + (data_bits+5) + par_en + (stop2 ? 2 : 1), range 7..12.
REQ-022 First RUN cycle SHALL present edge_cnt=0, bit_cnt=0 (the enable edge is edge 0 of the start bit).
REQ-023 In RUN, edge_cnt increments each cycle; at prescale-1 it wraps to 0, bit_end pulses, and bit_cnt increments.
REQ-024 mid = prescale>>1; sample_stb high when edge_cnt equals mid-1, mid, mid+1 with sample_idx 0, 1, 2 respectively.
REQ-025 When bit_cnt=FL-1 and edge_cnt=prescale-1: frame_end and bit_end pulse together; bit_cnt and edge_cnt wrap to 0; state stays RUN while enable is high (back-to-back frames, config not re-latched).
REQ-026 enable low in RUN or ERR: next state IDLE; edge_cnt and bit_cnt zero and all strobes low from the next cycle; no frame_end is issued for the aborted frame.
REQ-027 enable low and enable high on consecutive cycles SHALL restart at REQ-022 with fresh config latch.
REQ-028 In ERR, counters hold 0 and all strobes stay low; cfg_err set on entry and cleared only by rst or the next successful IDLE->RUN.
REQ-029 All strobes combinational from registered state only (no input-to-output path), zero additional latency.
REQ-030 Counter arithmetic SHALL be unsigned and truncated to declared widths; prescale-1 computed at PRESCALE_W bits.

Reset
REQ-031 On rst: state IDLE, edge_cnt=0, bit_cnt=0, sample_stb=0, sample_idx=0, bit_end=0, frame_end=0, cfg_err=0, latched config zero.
REQ-032 rst asserted mid-frame SHALL take effect immediately without any frame_end.

Structure
REQ-033 Shared package uart_rx_pkg SHALL hold the FSM state type, MIN_PRESCALE default, and frame-length constants (START_BITS, DATA_BASE=5).
REQ-034 One sub-module uart_rx_edge_cnt (wrapping edge counter with terminal-count pulse) SHALL be instantiated; FSM, bit counter and strobe decode stay in the top.

Verification
REQ-035 prescale=8, 8N1, enable held 80 cycles -> bit_end every 8th cycle, sample_stb at edge_cnt 3,4,5, frame_end once at cycle 80 with bit_cnt=9.
REQ-036 prescale=16, 5 data bits, par_en=1, stop2=1 -> FL=9, frame_end at cycle 144; second frame starts with bit_cnt=0 on cycle 145.
REQ-037 prescale changed 8->16 at bit_cnt=3 -> timing remains 8 edges/bit until enable drops.
REQ-038 enable dropped at bit_cnt=4, edge_cnt=5 -> next cycle counters 0, no frame_end; re-enable restarts at bit 0.
REQ-039 prescale=3 with enable high -> ERR, cfg_err=1, no strobes; enable low then high with prescale=8 -> RUN, cfg_err=0.
REQ-040 rst pulsed mid-frame at prescale=32 -> all outputs 0 asynchronously, IDLE on release.
